// File: rtl/data_mem_responder.sv
// data_mem_responder
// Responder end of the core's data-memory interface. Single-cycle word
// accesses: reads are combinational, writes take effect on the rising edge.
// Backing store is a word RAM plus a small system window at the top of the
// address space:
//   TOP-3 MTIME_LO   low half of the free-running 64-bit cycle counter
//   TOP-2 MTIME_HI   high half of the cycle counter
//   TOP-1 TOHOST     halt register; a write latches the value and halts
//   TOP   STATUS     {store_count|0, 14'b0, halt, 1'b1}, read-only
// Optional feature: define DMEM_STORE_COUNT_EN to add a 16-bit saturating
// count of accepted writes, shown in STATUS[31:16].
//
// Ports:
//   clk                   system clock, rising edge
//   rst                   asynchronous active-high reset
//   we_mem_data_i         write enable from core
//   addr_mem_data_i       word address from core
//   val_mem_data_write_i  store data from core
//   val_mem_data_read_o   load data to core (combinational)
//   halt_o                sticky halt, set by a TOHOST write
//   tohost_o              last value written to TOHOST

module data_mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_mem_data_i,
    input  logic [ADDR_WIDTH-1:0] addr_mem_data_i,
    input  logic [DATA_WIDTH-1:0] val_mem_data_write_i,
    output logic [DATA_WIDTH-1:0] val_mem_data_read_o,
    output logic                  halt_o,
    output logic [DATA_WIDTH-1:0] tohost_o
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS   = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_TOHOST   = ADDR_STATUS - ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MTIME_HI = ADDR_STATUS - ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MTIME_LO = ADDR_STATUS - ADDR_WIDTH'(3);

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] mtime_lo;
    logic [DATA_WIDTH-1:0] mtime_hi;
    logic [15:0]           store_count;
    logic [DATA_WIDTH-1:0] status;
    logic                  wr_ok;
    logic                  is_ram;

    assign wr_ok  = we_mem_data_i & ~halt_o;
    assign is_ram = (addr_mem_data_i < ADDR_MTIME_LO);

    // RAM has no reset; the rst term only discards a write that lands on
    // the same edge as an asserted reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok && is_ram) begin
            mem[addr_mem_data_i] <= val_mem_data_write_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime_lo <= '0;
            mtime_hi <= '0;
            tohost_o <= '0;
            halt_o   <= 1'b0;
        end else if (!halt_o) begin
            if (wr_ok && addr_mem_data_i == ADDR_MTIME_LO) begin
                // Load replaces this edge's increment; no carry into HI.
                mtime_lo <= val_mem_data_write_i;
            end else begin
                mtime_lo <= mtime_lo + DATA_WIDTH'(1);
                if (wr_ok && addr_mem_data_i == ADDR_MTIME_HI) begin
                    // Load wins over any carry out of LO on this edge.
                    mtime_hi <= val_mem_data_write_i;
                end else if (mtime_lo == {DATA_WIDTH{1'b1}}) begin
                    mtime_hi <= mtime_hi + DATA_WIDTH'(1);
                end
            end
            if (wr_ok && addr_mem_data_i == ADDR_TOHOST) begin
                tohost_o <= val_mem_data_write_i;
                halt_o   <= 1'b1;
            end
        end
    end

`ifdef DMEM_STORE_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            store_count <= '0;
        end else if (wr_ok && store_count != 16'hFFFF) begin
            store_count <= store_count + 16'd1;
        end
    end
`else
    assign store_count = '0;
`endif

    assign status = {store_count, 14'b0, halt_o, 1'b1};

    always_comb begin
        val_mem_data_read_o = '0;
        if (is_ram) begin
            val_mem_data_read_o = mem[addr_mem_data_i];
        end else begin
            case (addr_mem_data_i)
                ADDR_MTIME_LO: val_mem_data_read_o = mtime_lo;
                ADDR_MTIME_HI: val_mem_data_read_o = mtime_hi;
                ADDR_TOHOST:   val_mem_data_read_o = tohost_o;
                default:       val_mem_data_read_o = status;
            endcase
        end
    end

endmodule
